mem_load_unit: RTL and testbench
================================

# mem_load_unit

Load-side counterpart of the store byte-enable logic in the MEM stage. It accepts a load request (type and byte address) from the pipeline and checks alignment. It runs a req/ack read transaction on the data-memory bus with read byte enables, then extracts the addressed byte or halfword from the returned word and sign- or zero-extends it. While the transaction is outstanding it holds the pipeline stalled through `busy`.

## Interface
Parameters:
- `AW`, 32, byte-address width
- `DW`, 32, data width (fixed at 32; lane math assumes 4 bytes)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `ld_start`  in  1  load request; accepted only in IDLE
- `ld_op`  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 illegal
- `ld_addr`  in  AW  byte address
- `flush`  in  1  cancel the current/pending load
- `busy`  out  1  stall to pipeline
- `ld_valid`  out  1  one-cycle pulse, `ld_data` valid
- `ld_data`  out  32  extended load result
- `ld_err`  out  1  one-cycle pulse: misaligned address or illegal op
- `bus_req`  out  1  read request
- `bus_addr`  out  AW  word address, `ld_addr` with bits [1:0] forced to 00
- `bus_be`  out  4  read byte enables
- `bus_ack`  in  1  read data valid / request accepted
- `bus_rdata`  in  32  read word

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE + `ld_start` & !`flush`:
  - Misaligned or illegal request → ERR. Misaligned means lh/lhu with addr[0]=1, or lw with addr[1:0]≠00.
  - Otherwise → REQ. Latch op, addr[1:0], `bus_addr`, `bus_be`.
- Byte enables:
  - lw: 1111.
  - lh/lhu: addr[1]=1 → 1100, addr[1]=0 → 0011.
  - lb/lbu: one-hot at bit addr[1:0].
- REQ: `bus_req`=1, `busy`=1. `bus_req` and `bus_addr`/`bus_be` stay stable until an edge samples `bus_ack`=1.
  - At that edge, capture the extracted and extended word into `ld_data`.
  - If there was no flush → DONE.
  - If `flush` was seen at any cycle in REQ (sticky drop flag) → IDLE with no `ld_valid`, and `ld_data` is not updated.
- Lanes are little-endian:
  - Byte k = rdata[8k+7:8k], with k = addr[1:0].
  - Half = rdata[31:16] when addr[1]=1, rdata[15:0] when addr[1]=0.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- DONE: `ld_valid`=1 for one cycle → IDLE. `flush` in DONE has no effect; the consumer qualifies `ld_valid`.
- ERR: `ld_err`=1 for one cycle, no bus activity, `ld_data` unchanged → IDLE.
- `ld_start` outside IDLE is ignored. `ld_start` together with `flush` in IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `bus_req`, `busy`, `ld_valid`, `ld_err` = 0.
  - `ld_data`, `bus_addr` = 0; `bus_be` = 0000.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- Start accepted at edge E0 → `bus_req` high after E0.
- With `bus_ack` high in the first REQ cycle, capture happens at E1 and `ld_valid` is high E1→E2. Minimum latency is 2 cycles from start to result.
- Each wait cycle of `bus_ack` adds 1 cycle. There is no timeout.
- `busy` equals state==REQ. The pipeline must re-present nothing; the unit has its own latches.
- Error path: start at E0 → `ld_err` high E0→E1.
- `ld_data` holds its last captured value until the next successful capture.
- Async reset during REQ drops `bus_req` immediately; the bus slave must tolerate an abandoned request.
- A back-to-back load is accepted on the cycle after DONE or ERR, i.e. when the state is back in IDLE.

## Structure
- Shared package `mem_pkg`:
  - `ld_op` encodings (LD_W, LD_H, LD_HU, LD_B, LD_BU).
  - State enum.
  - BE constants (BE_WORD, BE_HI, BE_LO).
  - Reused by the store BE logic.
- Sub-module `load_extract`: combinational. Inputs are op, addr[1:0] and rdata; output is the 32-bit extended data. It is instantiated once at the capture path.
- The top level holds the FSM, latches, drop flag and bus registers.

## Test plan
- lb at 0x1003, rdata 0x80FF_0011, ack in first cycle → `bus_be`=1000, `bus_addr`=0x1000, `ld_data`=0xFFFF_FF80, `ld_valid` 2 cycles after start.
- lhu at 0x2002, rdata 0x8001_1234, ack after 3 wait cycles → `bus_be`=1100, `busy` high 4 cycles, `ld_data`=0x0000_8001; lh at 0x2000 on the same data → 0x0000_1234.
- lw at 0x3001 → `ld_err` pulse, `bus_req` never high, `ld_data` unchanged; op=111 at 0x3000 → `ld_err`.
- lw at 0x4000, `flush` pulsed in the 2nd REQ cycle, ack on the 4th → `bus_req` held until ack, no `ld_valid`, `ld_data` unchanged, IDLE afterwards.
- `rst_n` low mid-REQ → `bus_req`, `busy` = 0 immediately; after release a new lb load completes normally.
- `ld_start` held high continuously with alternating ops → exactly one transaction per IDLE visit, no start accepted in REQ/DONE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: load op encodings, load FSM states and byte-enable
// patterns, plus helpers reused by the store byte-enable logic.
package mem_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } ld_state_e;

  // True for an undefined op or an address not aligned to the access size.
  function automatic logic ld_bad(input logic [2:0] op, input logic [1:0] lane);
    logic bad;
    case (op)
      LD_W:        bad = (lane != 2'b00);
      LD_H, LD_HU: bad = lane[0];
      LD_B, LD_BU: bad = 1'b0;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] ld_be(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] be;
    case (op)
      LD_W:        be = BE_WORD;
      LD_H, LD_HU: be = lane[1] ? BE_HI : BE_LO;
      default:     be = 4'b0001 << lane;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed little-endian byte/halfword from a read word and
// sign- or zero-extends it according to the load op.
module load_extract
  import mem_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    byte_w = rdata_i[7:0];
    case (lane_i)
      2'd0: byte_w = rdata_i[7:0];
      2'd1: byte_w = rdata_i[15:8];
      2'd2: byte_w = rdata_i[23:16];
      2'd3: byte_w = rdata_i[31:24];
      default: byte_w = rdata_i[7:0];
    endcase
    half_w = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (op_i)
      LD_H:    data_o = {{16{half_w[15]}}, half_w};
      LD_HU:   data_o = {16'h0000, half_w};
      LD_B:    data_o = {{24{byte_w[7]}}, byte_w};
      LD_BU:   data_o = {24'h000000, byte_w};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// MEM-stage load unit: alignment check, req/ack read on the data bus with byte
// enables, then lane extraction and extension into ld_data.
//
// state | meaning
// IDLE  | waiting for ld_start; only state that accepts a request
// REQ   | bus_req held with stable addr/be until bus_ack; pipeline stalled
// DONE  | ld_valid pulse for the captured result
// ERR   | ld_err pulse for a misaligned or illegal request, no bus activity
module mem_load_unit
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic [2:0]    ld_op,
  input  logic [AW-1:0] ld_addr,
  input  logic          flush,
  output logic          busy,
  output logic          ld_valid,
  output logic [DW-1:0] ld_data,
  output logic          ld_err,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  ld_state_e     state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    lane_q, lane_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic          drop_q, drop_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic [DW-1:0] extracted;

  load_extract u_extract (
    .op_i    (op_q),
    .lane_i  (lane_q),
    .rdata_i (bus_rdata),
    .data_o  (extracted)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lane_d     = lane_q;
    bus_addr_d = bus_addr_q;
    bus_be_d   = bus_be_q;
    drop_d     = drop_q;
    ld_data_d  = ld_data_q;

    case (state_q)
      ST_IDLE: begin
        if (ld_start && !flush) begin
          if (ld_bad(ld_op, ld_addr[1:0])) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_REQ;
            op_d       = ld_op;
            lane_d     = ld_addr[1:0];
            bus_addr_d = {ld_addr[AW-1:2], 2'b00};
            bus_be_d   = ld_be(ld_op, ld_addr[1:0]);
            drop_d     = 1'b0;
          end
        end
      end
      ST_REQ: begin
        // The request is never withdrawn; a flush only suppresses the result.
        drop_d = drop_q | flush;
        if (bus_ack) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            ld_data_d = extracted;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= LD_W;
      lane_q     <= 2'b00;
      bus_addr_q <= '0;
      bus_be_q   <= 4'b0000;
      drop_q     <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q   <= bus_be_d;
      drop_q     <= drop_d;
      ld_data_q  <= ld_data_d;
    end
  end

  assign busy     = (state_q == ST_REQ);
  assign bus_req  = (state_q == ST_REQ);
  assign ld_valid = (state_q == ST_DONE);
  assign ld_err   = (state_q == ST_ERR);
  assign bus_addr = bus_addr_q;
  assign bus_be   = bus_be_q;
  assign ld_data  = ld_data_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: a driver/bus-slave pushes expected results
// computed from access-size arithmetic, a monitor pops them on ld_valid/ld_err.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_start;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic        flush;
  logic        busy;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_err;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_load_unit #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_start  (ld_start),
    .ld_op     (ld_op),
    .ld_addr   (ld_addr),
    .flush     (flush),
    .busy      (busy),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_err    (ld_err),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: everything derived from access size in bytes.
  function automatic int op_size(input int op);
    case (op)
      0:       return 4;
      1, 2:    return 2;
      3, 4:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input int op, input logic [31:0] a);
    int sz = op_size(op);
    return (sz != 0) && ((a % sz) == 0);
  endfunction

  function automatic logic [3:0] ref_be(input int op, input logic [31:0] a);
    int sz = op_size(op);
    int m  = ((1 << sz) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_data(input int op, input logic [31:0] a, input logic [31:0] rd);
    int sz = op_size(op);
    longint unsigned mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned v = ({32'h0, rd} >> (8 * (a % 4))) & mask;
    if ((op == 1 || op == 3) && (((v >> (8 * sz - 1)) & 1) == 1)) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic scramble();
    ld_op   = 3'($urandom_range(0, 7));
    ld_addr = $urandom;
  endtask

  // One load: drives the request, plays bus slave with 'delay' wait cycles,
  // optionally pulses flush in REQ cycle 'flush_at', keeps ld_start high if 'hold'.
  task automatic do_load(input int op, input logic [31:0] addr, input int delay,
                         input logic [31:0] rdata, input int flush_at, input bit hold);
    bit          legal;
    bit          dropped;
    logic [31:0] exp_d;
    logic [3:0]  be_exp;
    legal   = ref_legal(op, addr);
    dropped = 1'b0;
    exp_d   = model_data;
    be_exp  = ref_be(op, addr);

    @(negedge clk);
    ld_start = 1'b1;
    ld_op    = op[2:0];
    ld_addr  = addr;
    if (!legal) sb_q.push_back('{1'b1, model_data});
    @(negedge clk);
    if (hold) scramble(); else ld_start = 1'b0;

    if (!legal) begin
      check("err_no_bus_req", 32'(bus_req), 32'd0);
      check("err_pulse", 32'(ld_err), 32'd1);
      return;
    end

    check("bus_addr", bus_addr, addr & ~32'd3);
    for (int i = 0; i <= delay; i++) begin
      check("bus_req_held", 32'(bus_req), 32'd1);
      check("busy_in_req", 32'(busy), 32'd1);
      check("bus_be", 32'(bus_be), 32'(be_exp));
      flush = (i == flush_at);
      if (i == flush_at) dropped = 1'b1;
      bus_ack   = (i == delay);
      bus_rdata = (i == delay) ? rdata : $urandom;
      if (i == delay && !dropped) begin
        exp_d = ref_data(op, addr, rdata);
        sb_q.push_back('{1'b0, exp_d});
      end
      @(negedge clk);
      if (hold) scramble();
    end
    bus_ack = 1'b0;
    flush   = 1'b0;

    if (dropped) begin
      ld_start = 1'b0;
      check("drop_no_valid", 32'(ld_valid), 32'd0);
      check("drop_not_busy", 32'(busy), 32'd0);
      check("drop_data_kept", ld_data, model_data);
    end else begin
      check("valid_latency", 32'(ld_valid), 32'd1);
      check("done_not_busy", 32'(bus_req), 32'd0);
      model_data = exp_d;
    end
  endtask

  // Monitor: every result pulse must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ld_valid || ld_err) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: valid=%0b err=%0b data=0x%08h, required no pulse",
                   ld_valid, ld_err, ld_data);
        end else begin
          e = sb_q.pop_front();
          check("result_is_err", 32'(ld_err), 32'(e.is_err));
          check("result_valid", 32'(ld_valid), 32'(!e.is_err));
          check("ld_data", ld_data, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int dly;
    int fat;
    logic [31:0] a;
    rst_n     = 1'b0;
    ld_start  = 1'b0;
    ld_op     = 3'd0;
    ld_addr   = 32'h0;
    flush     = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(ld_valid), 32'd0);
    check("rst_err", 32'(ld_err), 32'd0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", 32'(bus_be), 32'h0);
    rst_n = 1'b1;

    // Directed cases from the plan.
    do_load(3, 32'h0000_1003, 0, 32'h80FF_0011, -1, 1'b0);
    check("lb_sign_value", ld_data, 32'hFFFF_FF80);
    do_load(2, 32'h0000_2002, 3, 32'h8001_1234, -1, 1'b0);
    check("lhu_value", ld_data, 32'h0000_8001);
    do_load(1, 32'h0000_2000, 1, 32'h8001_1234, -1, 1'b0);
    check("lh_value", ld_data, 32'h0000_1234);
    do_load(0, 32'h0000_3001, 0, 32'h0, -1, 1'b0);
    do_load(7, 32'h0000_3000, 0, 32'h0, -1, 1'b0);
    do_load(0, 32'h0000_4000, 3, 32'hDEAD_BEEF, 1, 1'b0);

    // Start together with flush in IDLE is ignored.
    @(negedge clk);
    ld_start = 1'b1; flush = 1'b1; ld_op = 3'd0; ld_addr = 32'h0000_6000;
    @(negedge clk);
    ld_start = 1'b0; flush = 1'b0;
    check("start_flush_ignored", 32'(bus_req), 32'd0);

    // Async reset in REQ.
    @(negedge clk);
    ld_start = 1'b1; ld_op = 3'd3; ld_addr = 32'h0000_5001;
    @(negedge clk);
    ld_start = 1'b0;
    check("pre_reset_req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_req", 32'(bus_req), 32'd0);
    check("reset_drops_busy", 32'(busy), 32'd0);
    check("reset_clears_data", ld_data, 32'h0);
    model_data = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load(3, 32'h0000_5001, 1, 32'h1234_7F00, -1, 1'b0);
    check("post_reset_lb", ld_data, 32'h0000_007F);

    // Randomized loads.
    for (int n = 0; n < 40; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(op_size(op) == 0 ? 32'd0 : 32'(op_size(op) - 1));
      dly = $urandom_range(0, 4);
      fat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly)) : -1;
      do_load(op, a, dly, $urandom, fat, 1'($urandom_range(0, 1)));
    end
    ld_start = 1'b0;

    // ld_start held high throughout, ops alternating, no flush.
    do_load(3, 32'h0000_7002, 2, 32'hA5C3_8E11, -1, 1'b1);
    do_load(0, 32'h0000_7100, 0, 32'h0102_0304, -1, 1'b1);
    do_load(4, 32'h0000_7203, 1, 32'hF000_0000, -1, 1'b1);
    do_load(1, 32'h0000_7302, 3, 32'h9ABC_0000, -1, 1'b1);
    do_load(0, 32'h0000_7402, 0, 32'h0, -1, 1'b1);
    do_load(2, 32'h0000_7500, 2, 32'h0000_F00D, -1, 1'b1);
    ld_start = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
